lru_set_tracker: RTL and testbench

- Sequential, parametrised successor to the combinational eviction_LRU victim selector.
- Owns the LRU state for every set of a cache, for any power-of-two associativity.
- Accepts touch (hit/fill), demote (invalidate) and query requests from the cache controller, and returns the updated packed LRU bits and the victim way one cycle later.
- Sits beside the tag array; one instance per cache (I and D caches each instantiate one, ASSOC=4 and ASSOC=8).

---
 rtl/lru_set_tracker_pkg.sv | 46 ++++
 rtl/lru_set_tracker_update_comb.sv | 36 +++
 rtl/lru_set_tracker.sv | 82 ++++++++
 tb/tb_lru_set_tracker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/lru_set_tracker_pkg.sv
// lru_pkg: shared LRU op encoding and generic reference update/victim functions
package lru_pkg;

    localparam int MAX_BITS = 64;

    typedef enum logic [1:0] {
        QUERY  = 2'b00,
        TOUCH  = 2'b01,
        DEMOTE = 2'b10
    } lru_op_e;

    typedef logic [MAX_BITS-1:0] lru_bits_t;

    // Counter of one way from packed state with ww bits per way
    function automatic logic [3:0] lru_get(lru_bits_t bits, int way, int ww);
        lru_bits_t s = bits >> (way * ww);
        return s[3:0] & 4'((1 << ww) - 1);
    endfunction

    // Packed next state of one set after op on way, for any associativity up to 16
    function automatic lru_bits_t lru_update(lru_bits_t bits, int way, lru_op_e op, int assoc);
        int ww = $clog2(assoc);
        logic [3:0] c = lru_get(bits, way, ww);
        logic [3:0] v;
        logic [3:0] n;
        lru_bits_t r = '0;
        for (int i = 0; i < assoc; i++) begin
            v = lru_get(bits, i, ww);
            n = (i == way) ? ((op == TOUCH) ? 4'(assoc - 1) : (op == DEMOTE) ? 4'd0 : v)
              : (op == TOUCH && v > c) ? v - 4'd1
              : (op == DEMOTE && v < c) ? v + 4'd1 : v;
            r |= lru_bits_t'(n) << (i * ww);
        end
        return r;
    endfunction

    // Lowest-index way whose counter is zero
    function automatic logic [3:0] lru_victim(lru_bits_t bits, int assoc);
        int ww = $clog2(assoc);
        logic [3:0] r = '0;
        for (int i = assoc - 1; i >= 0; i--)
            if (lru_get(bits, i, ww) == 4'd0) r = 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/lru_set_tracker_update_comb.sv
// lru_update_comb: combinational next-state and victim logic for one LRU set
module lru_update_comb
    import lru_pkg::*;
#(
    parameter int ASSOC = 8,
    localparam int WAY_W = $clog2(ASSOC)
) (
    input  logic [WAY_W*ASSOC-1:0] bits,
    input  logic [WAY_W-1:0]       way,
    input  lru_op_e                op,
    output logic [WAY_W*ASSOC-1:0] next_bits,
    output logic [WAY_W-1:0]       victim
);

    logic [WAY_W-1:0] cur;
    logic [WAY_W-1:0] c;

    assign cur = bits[way*WAY_W +: WAY_W];

    // Touch promotes to MRU and shifts younger ways down; demote sinks to LRU and shifts older ways up
    always_comb begin
        next_bits = bits;
        victim = '0;
        c = '0;
        for (int i = 0; i < ASSOC; i++) begin
            c = bits[i*WAY_W +: WAY_W];
            next_bits[i*WAY_W +: WAY_W] = (WAY_W'(i) == way)
                ? ((op == TOUCH) ? WAY_W'(ASSOC - 1) : (op == DEMOTE) ? '0 : c)
                : (op == TOUCH && c > cur) ? c - WAY_W'(1)
                : (op == DEMOTE && c < cur) ? c + WAY_W'(1) : c;
        end
        for (int i = ASSOC - 1; i >= 0; i--)
            if (next_bits[i*WAY_W +: WAY_W] == '0) victim = WAY_W'(i);
    end

endmodule

// File: rtl/lru_set_tracker.sv
// lru_set_tracker: per-set LRU state array with init sweep and one-cycle request/response
module lru_set_tracker
    import lru_pkg::*;
#(
    parameter int ASSOC = 8,
    parameter int SETS = 16,
    localparam int WAY_W = $clog2(ASSOC),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_op,
    input  logic [SET_W-1:0]       req_set,
    input  logic [WAY_W-1:0]       req_way,
    output logic                   rsp_valid,
    output logic [WAY_W-1:0]       rsp_victim,
    output logic [WAY_W*ASSOC-1:0] rsp_lru_bits,
    output logic                   init_done
);

    typedef enum logic {INIT, RUN} state_e;

    state_e                 state;
    logic [SET_W-1:0]       sweep;
    logic [WAY_W*ASSOC-1:0] mem [SETS];
    logic [WAY_W*ASSOC-1:0] ident;
    logic [WAY_W*ASSOC-1:0] next_bits;
    logic [WAY_W-1:0]       victim;
    lru_op_e                op;
    logic                   accept;

    assign op = (req_op == 2'b01) ? TOUCH : (req_op == 2'b10) ? DEMOTE : QUERY;
    assign accept = req_valid && req_ready;

    // Identity pattern written by the init sweep: way i holds counter i
    always_comb begin
        ident = '0;
        for (int i = 0; i < ASSOC; i++) ident[i*WAY_W +: WAY_W] = WAY_W'(i);
    end

    lru_update_comb #(.ASSOC(ASSOC)) u_update (
        .bits      (mem[req_set]),
        .way       (req_way),
        .op        (op),
        .next_bits (next_bits),
        .victim    (victim)
    );

    // State array: identity sweep during INIT, updated counters for accepted touch/demote
    always_ff @(posedge clk)
        if (state == INIT) mem[sweep] <= ident;
        else if (accept && op != QUERY) mem[req_set] <= next_bits;

    // Control FSM with registered handshake and response outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= INIT;
            sweep <= '0;
            req_ready <= 1'b0;
            init_done <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_victim <= '0;
            rsp_lru_bits <= '0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_victim <= victim;
                rsp_lru_bits <= next_bits;
            end
            if (state == INIT) begin
                sweep <= sweep + SET_W'(1);
                if (sweep == SET_W'(SETS - 1)) begin
                    state <= RUN;
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
            end
        end

endmodule

// File: tb/tb_lru_set_tracker.sv
// tb_lru_set_tracker: randomized self-checking bench for 8-way/16-set and 4-way/4-set trackers
module tb_lru_set_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_valid = 1'b0, a_ready, a_rsp_valid, a_done;
    logic [1:0]  a_op = '0;
    logic [3:0]  a_set = '0;
    logic [2:0]  a_way = '0, a_victim;
    logic [23:0] a_bits;

    logic        b_valid = 1'b0, b_ready, b_rsp_valid, b_done;
    logic [1:0]  b_op = '0;
    logic [1:0]  b_set = '0;
    logic [1:0]  b_way = '0, b_victim;
    logic [7:0]  b_bits;

    int passed = 0;
    int total = 0;

    int m [2][16][8];
    int nsets [2] = '{16, 4};
    int nways [2] = '{8, 4};
    int wbits [2] = '{3, 2};

    always #5 clk = ~clk;

    lru_set_tracker #(.ASSOC(8), .SETS(16)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_op(a_op),
        .req_set(a_set), .req_way(a_way), .rsp_valid(a_rsp_valid), .rsp_victim(a_victim),
        .rsp_lru_bits(a_bits), .init_done(a_done)
    );

    lru_set_tracker #(.ASSOC(4), .SETS(4)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_op(b_op),
        .req_set(b_set), .req_way(b_way), .rsp_valid(b_rsp_valid), .rsp_victim(b_victim),
        .rsp_lru_bits(b_bits), .init_done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        else passed++;
    endtask

    function automatic void model_init();
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 16; s++)
                for (int i = 0; i < 8; i++) m[d][s][i] = i;
    endfunction

    // Recency ranks: touch moves a way to the top, demote to the bottom, others close the gap
    function automatic void model_apply(int d, int s, int op, int w);
        int c = m[d][s][w];
        if (op == 1) begin
            for (int i = 0; i < nways[d]; i++) if (m[d][s][i] > c) m[d][s][i]--;
            m[d][s][w] = nways[d] - 1;
        end else if (op == 2) begin
            for (int i = 0; i < nways[d]; i++) if (m[d][s][i] < c) m[d][s][i]++;
            m[d][s][w] = 0;
        end
    endfunction

    function automatic logic [63:0] model_bits(int d, int s);
        logic [63:0] r = '0;
        for (int i = 0; i < nways[d]; i++) r |= 64'(m[d][s][i]) << (i * wbits[d]);
        return r;
    endfunction

    function automatic int model_victim(int d, int s);
        for (int i = 0; i < nways[d]; i++) if (m[d][s][i] == 0) return i;
        return -1;
    endfunction

    function automatic logic is_perm(int d, logic [63:0] bits);
        int seen = 0;
        for (int i = 0; i < nways[d]; i++)
            seen |= 1 << int'((bits >> (i * wbits[d])) & 64'((1 << wbits[d]) - 1));
        return seen == (1 << nways[d]) - 1;
    endfunction

    // One clock of stimulus on tracker d, then check the registered response
    task automatic cycle(input int d, input logic v, input int op, input int s, input int w, input string tag);
        logic [63:0] eb;
        int ev;
        if (d == 0) begin a_valid = v; a_op = 2'(op); a_set = 4'(s); a_way = 3'(w); end
        else begin b_valid = v; b_op = 2'(op); b_set = 2'(s); b_way = 2'(w); end
        if (v) model_apply(d, s, op, w);
        eb = model_bits(d, s);
        ev = model_victim(d, s);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk({tag, "_vld"}, d ? b_rsp_valid : a_rsp_valid, v);
        if (v) begin
            chk({tag, "_bits"}, d ? 64'(b_bits) : 64'(a_bits), eb);
            chk({tag, "_vic"}, d ? 64'(b_victim) : 64'(a_victim), 64'(ev));
        end
    endtask

    task automatic release_and_count(input string tag);
        int na = 0, nb = 0;
        rst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (a_ready && na == 0) na = i;
            if (b_ready && nb == 0) nb = i;
        end
        chk({tag, "_a_init_cycles"}, 64'(na), 64'd16);
        chk({tag, "_b_init_cycles"}, 64'(nb), 64'd4);
        chk({tag, "_a_done"}, a_done, 1'b1);
        chk({tag, "_b_done"}, b_done, 1'b1);
        model_init();
    endtask

    initial begin
        @(posedge clk);
        #1;
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_a_rspv", a_rsp_valid, 1'b0);
        chk("rst_a_bits", 64'(a_bits), 64'd0);
        chk("rst_a_vic", 64'(a_victim), 64'd0);
        chk("rst_a_done", a_done, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        release_and_count("init");

        cycle(0, 1, 0, 3, 0, "q_s3");
        chk("q_s3_ident", 64'(a_bits), 64'o76543210);
        cycle(0, 1, 1, 5, 0, "t_s5w0");
        chk("t_s5w0_const", 64'(a_bits), 64'o65432107);
        chk("t_s5w0_vic1", 64'(a_victim), 64'd1);
        cycle(0, 1, 1, 5, 1, "t_s5w1");
        chk("t_s5w1_vic2", 64'(a_victim), 64'd2);

        for (int w = 0; w < 8; w++) cycle(0, 1, 1, 2, w, "t_s2_seq");
        cycle(0, 1, 1, 2, 7, "t_s2_mru");
        chk("t_s2_mru_vic0", 64'(a_victim), 64'd0);

        cycle(0, 1, 2, 9, 6, "d_s9w6");
        chk("d_s9w6_vic6", 64'(a_victim), 64'd6);
        cycle(0, 1, 2, 9, 6, "d_s9_lru");
        cycle(0, 1, 3, 9, 2, "rsvd_s9");
        cycle(0, 0, 0, 0, 0, "idle");

        cycle(0, 1, 1, 1, 3, "b2b_t1");
        cycle(0, 1, 1, 1, 3, "b2b_t2");
        cycle(0, 1, 0, 1, 0, "b2b_q");
        chk("b2b_q_way3", 64'(a_bits[9 +: 3]), 64'd7);

        cycle(1, 1, 0, 2, 0, "b_q_s2");
        chk("b_q_s2_ident", 64'(b_bits), 64'b11100100);
        cycle(1, 1, 1, 1, 0, "b_t_s1w0");
        chk("b_t_s1w0_vic1", 64'(b_victim), 64'd1);
        cycle(1, 1, 2, 1, 3, "b_d_s1w3");

        for (int n = 0; n < 10000; n++) begin
            int d = $urandom_range(0, 1);
            logic v = $urandom_range(0, 3) != 0;
            cycle(d, v, $urandom_range(0, 3), $urandom_range(0, nsets[d] - 1),
                  $urandom_range(0, nways[d] - 1), "rnd");
            if (v) chk("rnd_perm", is_perm(d, d ? 64'(b_bits) : 64'(a_bits)), 1'b1);
        end

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_a_ready_low", a_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_a_done", a_done, 1'b0);
        release_and_count("reinit");
        cycle(0, 1, 0, 15, 0, "re_q_s15");
        cycle(1, 1, 0, 3, 0, "re_b_q_s3");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
